sap_ureg: RTL

- Parametrised universal register for the SAP-1 datapath. Generalises the fixed 8-bit load-only register to WIDTH bits.
- Adds per-cycle operation modes: load, increment, decrement, shift and rotate. Adds carry and zero status flags and a gated bus-drive output.
- Serves as the program counter, accumulator-shift and general W-bus register building block in later SAP revisions.

---
 rtl/sap_pkg.sv | 15 +
 rtl/sap_ureg_next.sv | 73 +++++++
 rtl/sap_ureg.sv | 54 +++++
 3 files changed

// File: rtl/sap_pkg.sv
// rtl/sap_pkg.sv - shared SAP mode encodings for the universal register
package sap_pkg;

  localparam int MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_INC  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_DEC  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b101;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b111;

endpackage

// File: rtl/sap_ureg_next.sv
// rtl/sap_ureg_next.sv - next value/carry for the universal register (SAP_UREG_SAT_EN selects saturating INC/DEC)
module sap_ureg_next
  import sap_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]  out,
  input  logic              carry,
  input  logic [WIDTH-1:0]  in,
  input  logic              ser_in,
  input  logic [MODE_W-1:0] mode,
  output logic [WIDTH-1:0]  next_out,
  output logic              next_carry
);

  localparam logic [WIDTH:0] ONE = (WIDTH+1)'(1);

  logic [WIDTH:0] inc_sum;
  logic [WIDTH:0] dec_diff;

  // Extra top bit of the widened sum/difference is the carry/borrow.
  assign inc_sum  = {1'b0, out} + ONE;
  assign dec_diff = {1'b0, out} - ONE;

  // Per-mode next state; anything unrecognised (including X) holds.
  always_comb begin
    next_out   = out;
    next_carry = carry;
    case (mode)
      MODE_LOAD: begin
        next_out   = in;
        next_carry = 1'b0;
      end
      MODE_INC: begin
`ifdef SAP_UREG_SAT_EN
        next_out   = inc_sum[WIDTH] ? out : inc_sum[WIDTH-1:0];
`else
        next_out   = inc_sum[WIDTH-1:0];
`endif
        next_carry = inc_sum[WIDTH];
      end
      MODE_DEC: begin
`ifdef SAP_UREG_SAT_EN
        next_out   = dec_diff[WIDTH] ? out : dec_diff[WIDTH-1:0];
`else
        next_out   = dec_diff[WIDTH-1:0];
`endif
        next_carry = dec_diff[WIDTH];
      end
      MODE_SHL: begin
        next_out   = {out[WIDTH-2:0], ser_in};
        next_carry = out[WIDTH-1];
      end
      MODE_SHR: begin
        next_out   = {ser_in, out[WIDTH-1:1]};
        next_carry = out[0];
      end
      MODE_ROL: begin
        next_out   = {out[WIDTH-2:0], out[WIDTH-1]};
        next_carry = out[WIDTH-1];
      end
      MODE_ROR: begin
        next_out   = {out[0], out[WIDTH-1:1]};
        next_carry = out[0];
      end
      default: begin
        next_out   = out;
        next_carry = carry;
      end
    endcase
  end

endmodule

// File: rtl/sap_ureg.sv
// rtl/sap_ureg.sv - SAP universal register top (optional SAP_UREG_SAT_EN: saturating INC/DEC)
module sap_ureg
  import sap_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [WIDTH-1:0]  in,
  input  logic              ser_in,
  input  logic [MODE_W-1:0] mode,
  input  logic              i_en,
  input  logic              o_en,
  output logic [WIDTH-1:0]  out,
  output logic [WIDTH-1:0]  bus_out,
  output logic              carry,
  output logic              zero
);

  localparam logic RST_ZERO = (RST_VAL == '0);

  logic [WIDTH-1:0] next_out;
  logic             next_carry;

  sap_ureg_next #(.WIDTH(WIDTH)) u_next (
    .out        (out),
    .carry      (carry),
    .in         (in),
    .ser_in     (ser_in),
    .mode       (mode),
    .next_out   (next_out),
    .next_carry (next_carry)
  );

  // State register: clr beats i_en, zero tracks the value being written.
  always_ff @(posedge clk) begin
    if (clr) begin
      out   <= RST_VAL;
      carry <= 1'b0;
      zero  <= RST_ZERO;
    end else if (!i_en) begin
      out   <= next_out;
      carry <= next_carry;
      zero  <= (next_out == '0);
    end
  end

  // Bus gate: drive contents only while o_en is low.
  always_comb begin
    bus_out = o_en ? '0 : out;
  end

endmodule
